// File: rtl/fpu_rob_dispatch.sv
`default_nettype none
// ============================================================================
// fpu_rob_dispatch
//   Round-robin dispatch of FP requests over NUM_LANES lanes, with in-order
//   result return through an epoch-tagged reorder buffer.
//   Revision: 1.0
// ============================================================================
module fpu_rob_dispatch #(
  parameter int NUM_LANES    = 2,
  parameter int ROB_DEPTH    = 8,
  parameter int WIDTH        = 64,
  parameter int REQ_WIDTH    = 256,
  parameter int STATUS_WIDTH = 5,
  parameter int TAG_WIDTH    = 4,
  localparam int IDXW        = $clog2(ROB_DEPTH),
  localparam int XW          = IDXW + 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [REQ_WIDTH-1:0]              in_req_i,
  input  logic [TAG_WIDTH-1:0]              in_tag_i,
  input  logic                              flush_i,
  output logic [NUM_LANES-1:0]              lane_valid_o,
  input  logic [NUM_LANES-1:0]              lane_ready_i,
  output logic [NUM_LANES*REQ_WIDTH-1:0]    lane_req_o,
  output logic [NUM_LANES*XW-1:0]           lane_rob_idx_o,
  output logic                              lane_flush_o,
  input  logic [NUM_LANES-1:0]              lane_out_valid_i,
  output logic [NUM_LANES-1:0]              lane_out_ready_o,
  input  logic [NUM_LANES*WIDTH-1:0]        lane_result_i,
  input  logic [NUM_LANES*STATUS_WIDTH-1:0] lane_status_i,
  input  logic [NUM_LANES*XW-1:0]           lane_rob_idx_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [WIDTH-1:0]                  result_o,
  output logic [STATUS_WIDTH-1:0]           status_o,
  output logic [TAG_WIDTH-1:0]              tag_o,
  output logic                              busy_o
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [XW-1:0]   FULL_CNT = XW'(ROB_DEPTH);
  localparam logic [XW-1:0]   CNT_ONE  = XW'(1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  logic [IDXW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [XW-1:0]           count_q, count_d;
  logic                    epoch_q, epoch_d;
  logic [LW-1:0]           rr_q, rr_d;
  logic [ROB_DEPTH-1:0]    alloc_q, alloc_d, done_q, done_d;
  logic [TAG_WIDTH-1:0]    tag_q  [ROB_DEPTH];
  logic [TAG_WIDTH-1:0]    tag_d  [ROB_DEPTH];
  logic [WIDTH-1:0]        res_q  [ROB_DEPTH];
  logic [WIDTH-1:0]        res_d  [ROB_DEPTH];
  logic [STATUS_WIDTH-1:0] stat_q [ROB_DEPTH];
  logic [STATUS_WIDTH-1:0] stat_d [ROB_DEPTH];

  logic [LW-1:0]           sel;
  logic                    accept;
  logic                    retire;
  logic [IDXW-1:0]         cidx [NUM_LANES];
  logic [NUM_LANES-1:0]    cwr;

  function automatic logic [LW-1:0] lane_wrap(input logic [LW-1:0] base, input int offs);
    int s;
    s = (int'(base) + offs) % NUM_LANES;
    return LW'(s);
  endfunction

  // Lowest offset from rr wins, so scan from the far end and let nearer lanes overwrite.
  always_comb begin
    sel = rr_q;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_ready_i[lane_wrap(rr_q, i)]) sel = lane_wrap(rr_q, i);
    end
  end

  assign in_ready_o       = !rst_i && !flush_i && (count_q != FULL_CNT) && (|lane_ready_i);
  assign accept           = in_valid_i && in_ready_o;
  assign out_valid_o      = !rst_i && alloc_q[head_q] && done_q[head_q];
  assign retire           = out_valid_o && out_ready_i && !flush_i;
  assign result_o         = res_q[head_q];
  assign status_o         = stat_q[head_q];
  assign tag_o            = tag_q[head_q];
  assign busy_o           = !rst_i && (count_q != '0);
  assign lane_flush_o     = flush_i;
  assign lane_out_ready_o = {NUM_LANES{~rst_i}};
  assign lane_req_o       = {NUM_LANES{in_req_i}};
  assign lane_rob_idx_o   = {NUM_LANES{epoch_q, tail_q}};

  always_comb begin
    lane_valid_o = '0;
    if (accept) lane_valid_o[sel] = 1'b1;
  end

  // Stale-epoch or unallocated responses are dropped here.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane_resp
    assign cidx[k] = lane_rob_idx_i[k*XW +: IDXW];
    assign cwr[k]  = lane_out_valid_i[k] && (lane_rob_idx_i[k*XW+IDXW] == epoch_q)
                     && alloc_q[lane_rob_idx_i[k*XW +: IDXW]];
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    epoch_d = epoch_q;
    rr_d    = rr_q;
    alloc_d = alloc_q;
    done_d  = done_q;
    tag_d   = tag_q;
    res_d   = res_q;
    stat_d  = stat_q;

    for (int k = 0; k < NUM_LANES; k++) begin
      if (cwr[k]) begin
        done_d[cidx[k]] = 1'b1;
        res_d[cidx[k]]  = lane_result_i[k*WIDTH +: WIDTH];
        stat_d[cidx[k]] = lane_status_i[k*STATUS_WIDTH +: STATUS_WIDTH];
      end
    end

    if (retire) begin
      alloc_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + IDX_ONE;
    end

    if (accept) begin
      alloc_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      tag_d[tail_q]   = in_tag_i;
      tail_d          = tail_q + IDX_ONE;
      rr_d            = lane_wrap(sel, 1);
    end

    case ({accept, retire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      alloc_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      epoch_d = ~epoch_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      epoch_q <= 1'b0;
      rr_q    <= '0;
      alloc_q <= '0;
      done_q  <= '0;
      for (int e = 0; e < ROB_DEPTH; e++) begin
        tag_q[e]  <= '0;
        res_q[e]  <= '0;
        stat_q[e] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      epoch_q <= epoch_d;
      rr_q    <= rr_d;
      alloc_q <= alloc_d;
      done_q  <= done_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      stat_q  <= stat_d;
    end
  end

endmodule
`default_nettype wire
